// File: rtl/match_ctrl.sv
// Match sequencer for pong: runs serve / play / point / pause / game-over flow,
// owns both player scores and gates the ball engine via play_en and serve_req.
module match_ctrl #(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 1500,
    parameter int POINT_TICKS = 750,
    parameter int FLASH_TICKS = 375,
    parameter int CNTWIDTH    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       out_left,
    input  logic       out_right,
    output logic [2:0] state,
    output logic       play_en,
    output logic       serve_req,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over,
    output logic       winner,
    output logic       flash
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_PLAY       = 3'd2,
        ST_POINT      = 3'd3,
        ST_PAUSED     = 3'd4,
        ST_GAME_OVER  = 3'd5
    } state_t;

    localparam logic [CNTWIDTH-1:0] SERVE_LD = CNTWIDTH'(SERVE_TICKS);
    localparam logic [CNTWIDTH-1:0] POINT_LD = CNTWIDTH'(POINT_TICKS);
    localparam logic [CNTWIDTH-1:0] FLASH_LD = CNTWIDTH'(FLASH_TICKS);
    localparam logic [CNTWIDTH-1:0] CNT_ONE  = CNTWIDTH'(1);
    localparam logic [3:0]          WIN_LD   = 4'(WIN_SCORE);

    state_t              state_q, state_d;
    logic [CNTWIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]          score_p1_q, score_p1_d;
    logic [3:0]          score_p2_q, score_p2_d;
    logic                serve_dir_q, serve_dir_d;
    logic                serve_req_q, serve_req_d;
    logic                play_en_q, play_en_d;
    logic                game_over_q, game_over_d;
    logic                winner_q, winner_d;
    logic                flash_q, flash_d;
    logic                start_q, start_d;

    logic                start_e;
    logic                left_only;
    logic                right_only;
    logic                any_out;
    logic                cnt_last;
    logic [3:0]          p1_inc;
    logic [3:0]          p2_inc;

    assign start_e    = start & ~start_q;
    assign left_only  = out_left & ~out_right;
    assign right_only = out_right & ~out_left;
    assign any_out    = out_left | out_right;
    assign cnt_last   = (cnt_q == CNT_ONE);
    assign p1_inc     = score_p1_q + 4'd1;
    assign p2_inc     = score_p2_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        serve_dir_d = serve_dir_q;
        serve_req_d = 1'b0;
        winner_d    = winner_q;
        flash_d     = flash_q;
        start_d     = start;

        unique case (state_q)
            ST_IDLE: begin
                if (start_e) begin
                    score_p1_d  = 4'd0;
                    score_p2_d  = 4'd0;
                    serve_dir_d = 1'b0;
                    cnt_d       = SERVE_LD;
                    state_d     = ST_SERVE_WAIT;
                end
            end

            ST_SERVE_WAIT: begin
                if (tick) begin
                    if (cnt_last) begin
                        serve_req_d = 1'b1;
                        state_d     = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            ST_PLAY: begin
                // Simultaneous out pulses cancel; a score always beats a start edge.
                if (left_only) begin
                    score_p2_d  = p2_inc;
                    serve_dir_d = 1'b1;
                    if (p2_inc == WIN_LD) begin
                        winner_d = 1'b1;
                        flash_d  = 1'b1;
                        cnt_d    = FLASH_LD;
                        state_d  = ST_GAME_OVER;
                    end else begin
                        cnt_d   = POINT_LD;
                        state_d = ST_POINT;
                    end
                end else if (right_only) begin
                    score_p1_d  = p1_inc;
                    serve_dir_d = 1'b0;
                    if (p1_inc == WIN_LD) begin
                        winner_d = 1'b0;
                        flash_d  = 1'b1;
                        cnt_d    = FLASH_LD;
                        state_d  = ST_GAME_OVER;
                    end else begin
                        cnt_d   = POINT_LD;
                        state_d = ST_POINT;
                    end
                end else if (start_e && !any_out) begin
                    state_d = ST_PAUSED;
                end
            end

            ST_PAUSED: begin
                if (start_e) begin
                    state_d = ST_PLAY;
                end
            end

            ST_POINT: begin
                if (tick) begin
                    if (cnt_last) begin
                        cnt_d   = SERVE_LD;
                        state_d = ST_SERVE_WAIT;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            ST_GAME_OVER: begin
                // A restart takes priority over the flash timer on the same cycle.
                if (start_e) begin
                    score_p1_d  = 4'd0;
                    score_p2_d  = 4'd0;
                    serve_dir_d = 1'b0;
                    flash_d     = 1'b0;
                    cnt_d       = SERVE_LD;
                    state_d     = ST_SERVE_WAIT;
                end else if (tick) begin
                    if (cnt_last) begin
                        flash_d = ~flash_q;
                        cnt_d   = FLASH_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        play_en_d   = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_GAME_OVER);
    end

    // start_q resets high so a button held through reset release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            score_p1_q  <= 4'd0;
            score_p2_q  <= 4'd0;
            serve_dir_q <= 1'b0;
            serve_req_q <= 1'b0;
            play_en_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            flash_q     <= 1'b0;
            start_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            serve_dir_q <= serve_dir_d;
            serve_req_q <= serve_req_d;
            play_en_q   <= play_en_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            flash_q     <= flash_d;
            start_q     <= start_d;
        end
    end

    assign state     = state_q;
    assign play_en   = play_en_q;
    assign serve_req = serve_req_q;
    assign serve_dir = serve_dir_q;
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign flash     = flash_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed, table-driven bench for match_ctrl with small tick periods.
module tb_match_ctrl;

    localparam int S_IDLE = 0, S_SW = 1, S_PLAY = 2, S_POINT = 3, S_PAUSED = 4, S_GO = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b1;
    logic       out_left = 1'b0;
    logic       out_right = 1'b0;
    logic [2:0] state;
    logic       play_en, serve_req, serve_dir, game_over, winner, flash;
    logic [3:0] score_p1, score_p2;

    match_ctrl #(
        .WIN_SCORE(2), .SERVE_TICKS(3), .POINT_TICKS(2), .FLASH_TICKS(2), .CNTWIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .out_left(out_left), .out_right(out_right),
        .state(state), .play_en(play_en), .serve_req(serve_req), .serve_dir(serve_dir),
        .score_p1(score_p1), .score_p2(score_p2), .game_over(game_over),
        .winner(winner), .flash(flash)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s, l, r, ticks;
        int st, pe, sr, sd, p1, p2, go, win, fl;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs[NV];

    int n_pass = 0;
    int n_total = 0;
    int tick_cnt = 0;

    function automatic vec_t mk(int s, int l, int r, int ticks, int st, int pe, int sr,
                                int sd, int p1, int p2, int go, int win, int fl);
        vec_t v;
        v.s = s; v.l = l; v.r = r; v.ticks = ticks;
        v.st = st; v.pe = pe; v.sr = sr; v.sd = sd;
        v.p1 = p1; v.p2 = p2; v.go = go; v.win = win; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".state"},     int'(state),     v.st);
        chk({tag, ".play_en"},   int'(play_en),   v.pe);
        chk({tag, ".serve_req"}, int'(serve_req), v.sr);
        chk({tag, ".serve_dir"}, int'(serve_dir), v.sd);
        chk({tag, ".score_p1"},  int'(score_p1),  v.p1);
        chk({tag, ".score_p2"},  int'(score_p2),  v.p2);
        chk({tag, ".game_over"}, int'(game_over), v.go);
        chk({tag, ".winner"},    int'(winner),    v.win);
        chk({tag, ".flash"},     int'(flash),     v.fl);
    endtask

    // Free-running tick: high on every 4th clock of the cadence.
    task automatic step();
        tick = (tick_cnt == 3);
        @(posedge clk);
        #1;
        tick_cnt = tick ? 0 : tick_cnt + 1;
    endtask

    // Input-change clock: tick held low so pulses never coincide with a tick.
    task automatic pulse_clk(input int s, input int l, input int r);
        start = s[0];
        out_left = l[0];
        out_right = r[0];
        tick = 1'b0;
        @(posedge clk);
        #1;
        tick_cnt = 0;
        out_left = 1'b0;
        out_right = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        int seen;
        seen = 0;
        while (seen < n) begin
            step();
            if (tick) seen++;
        end
    endtask

    initial begin
        vec_t rst_v;
        rst_v = mk(0, 0, 0, 0, S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);

        //              s  l  r  tk  state    pe sr sd p1 p2 go win fl
        vecs[0]  = mk(1, 0, 0, 0, S_IDLE,   0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, S_IDLE,   0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, S_SW,     0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 2, S_SW,     0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, S_PLAY,   1, 1, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, S_PLAY,   1, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, S_POINT,  0, 0, 0, 1, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 1, S_POINT,  0, 0, 0, 1, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 1, S_SW,     0, 0, 0, 1, 0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 0, 2, S_SW,     0, 0, 0, 1, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 1, S_PLAY,   1, 1, 0, 1, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 1, 0, S_PLAY,   1, 0, 0, 1, 0, 0, 0, 0);
        vecs[12] = mk(1, 0, 0, 0, S_PAUSED, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 0, 2, S_PAUSED, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 0, S_PLAY,   1, 0, 0, 1, 0, 0, 0, 0);
        vecs[15] = mk(0, 1, 0, 0, S_POINT,  0, 0, 1, 1, 1, 0, 0, 0);
        vecs[16] = mk(0, 1, 0, 1, S_POINT,  0, 0, 1, 1, 1, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, 1, S_SW,     0, 0, 1, 1, 1, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 3, S_PLAY,   1, 1, 1, 1, 1, 0, 0, 0);
        vecs[19] = mk(0, 1, 0, 0, S_GO,     0, 0, 1, 1, 2, 1, 1, 1);
        vecs[20] = mk(0, 0, 0, 1, S_GO,     0, 0, 1, 1, 2, 1, 1, 1);
        vecs[21] = mk(0, 0, 0, 1, S_GO,     0, 0, 1, 1, 2, 1, 1, 0);
        vecs[22] = mk(0, 0, 0, 2, S_GO,     0, 0, 1, 1, 2, 1, 1, 1);
        vecs[23] = mk(1, 0, 0, 0, S_SW,     0, 0, 0, 0, 0, 0, 1, 0);
        vecs[24] = mk(0, 0, 0, 3, S_PLAY,   1, 1, 0, 0, 0, 0, 1, 0);
        vecs[25] = mk(0, 0, 1, 0, S_POINT,  0, 0, 0, 1, 0, 0, 1, 0);
        vecs[26] = mk(0, 0, 0, 2, S_SW,     0, 0, 0, 1, 0, 0, 1, 0);
        vecs[27] = mk(0, 0, 0, 3, S_PLAY,   1, 1, 0, 1, 0, 0, 1, 0);
        vecs[28] = mk(0, 1, 0, 0, S_POINT,  0, 0, 1, 1, 1, 0, 1, 0);

        // Reset held with start high.
        repeat (3) @(posedge clk);
        #1;
        chk_all("in_reset", rst_v);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            pulse_clk(vecs[i].s, vecs[i].l, vecs[i].r);
            run_ticks(vecs[i].ticks);
            chk_all($sformatf("r%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-POINT at 1/1: outputs clear before any clock edge.
        #2;
        reset = 1'b0;
        #1;
        chk_all("mid_reset", rst_v);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) step();
        chk("post_reset.state_idle", int'(state), S_IDLE);
        pulse_clk(1, 0, 0);
        chk("post_reset.new_start", int'(state), S_SW);
        chk("post_reset.score_p1", int'(score_p1), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
Match sequencer for the pong top level. It runs the game flow: idle, serve countdown, play, point pause, pause and game over. It owns the player scores and gates the ball engine through play_en and serve_req. It consumes the engine's out_left/out_right pulses, and its score outputs feed the scoreboard multiplexer.

Parameters:
WIN_SCORE, 9, points needed to win; legal range 1..15
SERVE_TICKS, 1500, ticks from entering SERVE_WAIT until the serve; must be >=1
POINT_TICKS, 750, ticks spent in POINT after a score; must be >=1
FLASH_TICKS, 375, ticks per half-period of flash in GAME_OVER; must be >=1
CNTWIDTH, 16, width of the internal tick counter; every *_TICKS value must fit in it

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle game-rate strobe (game clock rate)
start  in  1  debounced start button, level
out_left  in  1  one-cycle pulse: ball left the field on player1's side
out_right  in  1  one-cycle pulse: ball left the field on player2's side
state  out  3  IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, PAUSED=4, GAME_OVER=5
play_en  out  1  ball engine may advance
serve_req  out  1  one-cycle pulse: engine re-centres the ball and launches it
serve_dir  out  1  0 = launch toward player2 (right), 1 = toward player1 (left)
score_p1  out  4  player1 score
score_p2  out  4  player2 score
game_over  out  1  high while in GAME_OVER
winner  out  1  0 = player1, 1 = player2; valid while game_over=1
flash  out  1  scoreboard blink enable

Behaviour:
- All state and outputs are registered.
- While reset=0: state=IDLE, play_en=0, serve_req=0, serve_dir=0, scores=0, game_over=0, winner=0, flash=0, cnt=0, start_q=1.
- start_q=1 at reset blocks a spurious edge if start is held during reset release.
- Start edge: start_e = start & ~start_q; start_q samples start every clk.
- Counter: cnt decrements only on cycles with tick=1.
- play_en=1 only in PLAY.
- out_left/out_right are ignored in every state except PLAY.
- IDLE:
  - On start_e: scores<=0, serve_dir<=0, cnt<=SERVE_TICKS, go to SERVE_WAIT.
- SERVE_WAIT:
  - On tick with cnt==1: go to PLAY and set serve_req=1 for exactly one clk, coincident with the first PLAY cycle.
  - On tick otherwise: cnt<=cnt-1.
  - start_e is ignored.
- PLAY:
  - out_left alone: score_p2<=score_p2+1, serve_dir<=1.
  - out_right alone: score_p1<=score_p1+1, serve_dir<=0.
  - After a score: if the new score == WIN_SCORE, go to GAME_OVER with winner = the scorer, cnt<=FLASH_TICKS, flash<=1. Otherwise go to POINT with cnt<=POINT_TICKS.
  - out_left and out_right in the same cycle: both ignored, stay in PLAY.
  - start_e with no out pulse: go to PAUSED.
  - start_e together with an out pulse: the score wins, start_e is dropped.
- PAUSED:
  - play_en=0, cnt frozen, out pulses ignored.
  - start_e returns to PLAY. No serve_req is issued; the ball resumes in place.
- POINT:
  - On tick with cnt==1: cnt<=SERVE_TICKS, go to SERVE_WAIT.
  - On tick otherwise: decrement cnt.
  - start_e is ignored.
- GAME_OVER:
  - game_over=1; scores are held.
  - On tick with cnt==1: flash toggles, cnt<=FLASH_TICKS. On tick otherwise: decrement cnt.
  - start_e: scores<=0, serve_dir<=0, game_over<=0, flash<=0, cnt<=SERVE_TICKS, go to SERVE_WAIT.
- Scores:
  - Can never exceed WIN_SCORE, so the 4-bit values never wrap.
  - Cleared only by reset or at the start of a new game.
- Reset asserted mid-match: immediate return to the reset values; the next match needs a new start edge.
- Latency: an out pulse at cycle N produces updated score/state at N+1. A terminal tick at cycle N produces the state change at N+1.

Test Plan:
Bench parameters: WIN_SCORE=2, SERVE_TICKS=3, POINT_TICKS=2, FLASH_TICKS=2; tick every 4th clk.
1. Reset release with start already high -> state stays IDLE. Then start low then high -> SERVE_WAIT; on the 3rd tick the next clk shows state=PLAY, play_en=1, serve_req=1 for one clk only, serve_dir=0.
2. In PLAY, out_right pulse -> score_p1=1, serve_dir=0, state=POINT, play_en=0. After 2 ticks -> SERVE_WAIT. After 3 more ticks -> PLAY with serve_req=1.
3. In PLAY, out_left and out_right in the same clk -> scores unchanged, state=PLAY. Out pulses sent during SERVE_WAIT and POINT -> no score change.
4. In PLAY, start edge -> PAUSED, play_en=0; out_left during PAUSED is ignored. Second start edge -> PLAY with no serve_req.
5. Two out_left pulses across serves -> score_p2=2, game_over=1, winner=1, state=GAME_OVER. flash toggles every 2 ticks. Start edge -> scores 0/0, flash=0, SERVE_WAIT.
6. Pull reset low during POINT with score 1/1 -> all outputs return to reset values immediately, state=IDLE.
